// File: rtl/gemm_pkg.sv
// Shared GEMM datapath defaults and the requantiser control FSM encoding.
package gemm_pkg;

  localparam int DEF_BLOCK_OUT   = 16;
  localparam int DEF_ACC_WIDTH   = 32;
  localparam int DEF_OUT_WIDTH   = 8;
  localparam int DEF_SHIFT_WIDTH = 5;
  localparam int DEF_CNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/requant_lane.sv
// One requantiser lane: round + arithmetic shift (first half), clip to output range (second half).
module requant_lane import gemm_pkg::*; #(
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]   acc,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic signed [ACC_WIDTH:0]     rnd_shr,
  input  logic signed [ACC_WIDTH:0]     shr_in,
  output logic signed [OUT_WIDTH-1:0]   q,
  output logic                          sat
);

  localparam logic signed [ACC_WIDTH:0] MAX_V = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] MIN_V = ~MAX_V;

  // One extra bit of headroom keeps acc + half-LSB from overflowing; shifts past the
  // width simply fill with the sign bit.
  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0]   a,
    input logic        [SHIFT_WIDTH-1:0] sh
  );
    logic signed [ACC_WIDTH:0] bias;
    logic signed [ACC_WIDTH:0] t;
    bias = '0;
    if (sh != '0) bias = (ACC_WIDTH+1)'(1) << (sh - 1'b1);
    t = {a[ACC_WIDTH-1], a} + bias;
    return t >>> sh;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [OUT_WIDTH:0] clip(input logic signed [ACC_WIDTH:0] r);
    if (r > MAX_V)      return {1'b1, MAX_V[OUT_WIDTH-1:0]};
    else if (r < MIN_V) return {1'b1, MIN_V[OUT_WIDTH-1:0]};
    else                return {1'b0, r[OUT_WIDTH-1:0]};
  endfunction

  assign rnd_shr  = round_shift(acc, shift);
  assign {sat, q} = clip(shr_in);

endmodule

// File: rtl/acc_requant_stream.sv
// Streams accumulator vectors through a 2-stage round/shift/clip pipeline with valid/ready on both sides.
module acc_requant_stream import gemm_pkg::*; #(
  parameter int BLOCK_OUT   = DEF_BLOCK_OUT,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_start,
  input  logic [SHIFT_WIDTH-1:0]         cfg_shift,
  input  logic [CNT_WIDTH-1:0]           cfg_len,
  output logic                           busy,
  output logic                           done,
  output logic                           sat_flag,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [BLOCK_OUT*ACC_WIDTH-1:0] s_acc,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [BLOCK_OUT*OUT_WIDTH-1:0] m_data,
  output logic                           m_last
);

  localparam int RW = ACC_WIDTH + 1;

  state_t                  state_q, state_d;
  logic [SHIFT_WIDTH-1:0]  shift_q;
  logic [CNT_WIDTH-1:0]    len_q, in_cnt, out_cnt;
  logic                    vld_p1, vld_p2;
  logic signed [RW-1:0]    shr_s1 [BLOCK_OUT];
  logic signed [RW-1:0]    shr_p1 [BLOCK_OUT];
  logic [BLOCK_OUT*OUT_WIDTH-1:0] q_s2;
  logic [BLOCK_OUT-1:0]    sat_s2;
  logic                    start_acc, adv1, adv2, s_fire, m_fire, last_out;

  assign start_acc = (state_q == ST_IDLE) && cfg_start;
  assign adv2      = !vld_p2 || m_ready;
  assign adv1      = !vld_p1 || adv2;
  assign s_ready   = (state_q == ST_RUN) && (in_cnt < len_q) && adv1;
  assign s_fire    = s_valid && s_ready;
  assign m_valid   = vld_p2;
  assign m_fire    = vld_p2 && m_ready;
  assign last_out  = (out_cnt == len_q - CNT_WIDTH'(1));
  assign m_last    = vld_p2 && last_out;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

  for (genvar i = 0; i < BLOCK_OUT; i++) begin : g_lane
    requant_lane #(
      .ACC_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .acc    (s_acc[i*ACC_WIDTH +: ACC_WIDTH]),
      .shift  (shift_q),
      .rnd_shr(shr_s1[i]),
      .shr_in (shr_p1[i]),
      .q      (q_s2[i*OUT_WIDTH +: OUT_WIDTH]),
      .sat    (sat_s2[i])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_start) state_d = (cfg_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (s_fire && (in_cnt == len_q - CNT_WIDTH'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if (m_fire && last_out) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      len_q    <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      sat_flag <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        shift_q  <= cfg_shift;
        len_q    <= cfg_len;
        in_cnt   <= '0;
        out_cnt  <= '0;
        sat_flag <= 1'b0;
      end else begin
        if (s_fire) in_cnt <= in_cnt + CNT_WIDTH'(1);
        if (m_fire) out_cnt <= out_cnt + CNT_WIDTH'(1);
        if (vld_p1 && adv2 && (|sat_s2)) sat_flag <= 1'b1;
      end
      if (adv1) vld_p1 <= s_fire;
      if (adv2) vld_p2 <= vld_p1;
    end
  end

  // Stage 0 -> 1: rounded and shifted lanes
  always_ff @(posedge clk) begin
    if (s_fire) begin
      for (int i = 0; i < BLOCK_OUT; i++) shr_p1[i] <= shr_s1[i];
    end
  end

  // Stage 1 -> 2: clipped output vector
  always_ff @(posedge clk) begin
    if (rst) m_data <= '0;
    else if (vld_p1 && adv2) m_data <= q_s2;
  end

endmodule

// File: tb/tb_acc_requant_stream.sv
// Directed bench for acc_requant_stream with a queue-based reference model and per-cycle monitor.
module tb_acc_requant_stream;

  localparam int BO  = 16;
  localparam int AW  = 32;
  localparam int OW  = 8;
  localparam int SW  = 5;
  localparam int CW  = 16;
  localparam int AVW = BO*AW;
  localparam int OVW = BO*OW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_start = 1'b0;
  logic [SW-1:0]  cfg_shift = '0;
  logic [CW-1:0]  cfg_len = '0;
  logic           busy, done, sat_flag;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [AVW-1:0] s_acc = '0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [OVW-1:0] m_data;
  logic           m_last;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  acc_requant_stream dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_shift(cfg_shift), .cfg_len(cfg_len),
    .busy(busy), .done(done), .sat_flag(sat_flag),
    .s_valid(s_valid), .s_ready(s_ready), .s_acc(s_acc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic chkv(input string nm, input logic [OVW-1:0] act, input logic [OVW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  function automatic logic [AVW-1:0] mk(input int a0, input int a1, input int a2, input int a3);
    logic [AVW-1:0] v;
    v = '0;
    v[0*AW +: AW] = a0;
    v[1*AW +: AW] = a1;
    v[2*AW +: AW] = a2;
    v[3*AW +: AW] = a3;
    return v;
  endfunction

  function automatic int lane(input logic [OVW-1:0] v, input int i);
    return int'($signed(v[i*OW +: OW]));
  endfunction

  // Reference: round-half-up by adding half an LSB, floor-shift, clip to int8.
  function automatic logic [OVW-1:0] model_vec(input logic [AVW-1:0] a, input int sh, output bit sat);
    logic [OVW-1:0] o;
    longint x, t;
    o = '0;
    sat = 1'b0;
    for (int i = 0; i < BO; i++) begin
      x = longint'($signed(a[i*AW +: AW]));
      t = x + ((sh != 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
      t = t >>> sh;
      if (t > 127) begin t = 127; sat = 1'b1; end
      else if (t < -128) begin t = -128; sat = 1'b1; end
      o[i*OW +: OW] = t[OW-1:0];
    end
    return o;
  endfunction

  logic [OVW-1:0] exp_q [$];
  int             model_len, model_shift, out_idx, acc_cnt;
  bit             model_sat, prev_done_ev, hold_valid, hold_last;
  logic [OVW-1:0] hold_data, last_out;

  always @(negedge clk) begin : mon
    bit             sat_v, exp_last, start_acc;
    logic [OVW-1:0] ev;
    if (rst) begin
      exp_q.delete();
      model_len = 0; model_shift = 0; out_idx = 0; acc_cnt = 0;
      model_sat = 1'b0; prev_done_ev = 1'b0; hold_valid = 1'b0;
    end else begin
      if (done || prev_done_ev) chk("done_timing", done, prev_done_ev);
      if (done) chk("sat_flag_at_done", sat_flag, model_sat);
      if (hold_valid) begin
        chk("hold_valid", m_valid, 1);
        chkv("hold_data", m_data, hold_data);
        chk("hold_last", m_last, hold_last);
      end
      start_acc = cfg_start && !busy && !done;
      exp_last  = 1'b0;
      if (start_acc) begin
        model_len = int'(cfg_len); model_shift = int'(cfg_shift);
        out_idx = 0; acc_cnt = 0; model_sat = 1'b0;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(model_vec(s_acc, model_shift, sat_v));
        model_sat = model_sat | sat_v;
        acc_cnt++;
      end
      if (m_valid && m_ready) begin
        exp_last = (out_idx == model_len - 1);
        if (exp_q.size() == 0) chk("unexpected_output", m_valid, 0);
        else begin
          ev = exp_q.pop_front();
          chkv("m_data", m_data, ev);
        end
        chk("m_last", m_last, exp_last);
        out_idx++;
        last_out = m_data;
      end
      hold_valid   = m_valid && !m_ready;
      hold_data    = m_data;
      hold_last    = m_last;
      prev_done_ev = (m_valid && m_ready && exp_last) || (start_acc && (cfg_len == '0));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int sh);
    cfg_start = 1'b1;
    cfg_len   = CW'(len);
    cfg_shift = SW'(sh);
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [AVW-1:0] v);
    bit hs;
    int c;
    c = 0;
    s_valid = 1'b1;
    s_acc   = v;
    do begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      c++;
    end while (!hs && c < 100);
    if (!hs) chk("send_timeout", s_ready, 1);
  endtask

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    @(negedge clk);
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk(nm, done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_sat"}, sat_flag, 0);
    chk({nm, "_s_ready"}, s_ready, 0);
    chk({nm, "_m_valid"}, m_valid, 0);
    chk({nm, "_m_last"}, m_last, 0);
    chkv({nm, "_m_data"}, m_data, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;

    // Test 1: shift 0, saturation on lanes 2 and 3
    start_job(1, 0);
    send(mk(100, -100, 200, -300));
    s_valid = 1'b0;
    wait_done("t1_done");
    chk("t1_l0", lane(last_out, 0), 100);
    chk("t1_l1", lane(last_out, 1), -100);
    chk("t1_l2", lane(last_out, 2), 127);
    chk("t1_l3", lane(last_out, 3), -128);
    chk("t1_sat_sticky", sat_flag, 1);

    // Test 2: shift 4 rounding, two-cycle latency, single-cycle done
    start_job(1, 4);
    send(mk(24, -24, 7, -9));
    s_valid = 1'b0;
    @(negedge clk);
    chk("t2_lat1", m_valid, 0);
    @(negedge clk);
    chk("t2_lat2", m_valid, 1);
    wait_done("t2_done");
    chk("t2_l0", lane(last_out, 0), 2);
    chk("t2_l1", lane(last_out, 1), -1);
    chk("t2_l2", lane(last_out, 2), 0);
    chk("t2_l3", lane(last_out, 3), -1);
    chk("t2_sat", sat_flag, 0);
    @(negedge clk);
    chk("t2_done_pulse", done, 0);
    @(posedge clk); #1;

    // Test 3: backpressure with s_valid held high
    m_ready = 1'b0;
    start_job(3, 0);
    fork
      begin
        send(mk(1, 2, 3, 4));
        send(mk(-5, 6, 300, 8));
        send(mk(9, 10, 11, -1000));
        s_valid = 1'b0;
      end
      begin
        tick(4);
        @(negedge clk);
        chk("t3_accepted", acc_cnt, 2);
        chk("t3_s_ready_low", s_ready, 0);
        chk("t3_m_valid", m_valid, 1);
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_done("t3_done");
    chk("t3_l0", lane(last_out, 0), 9);
    chk("t3_l3", lane(last_out, 3), -128);

    // Test 4: zero-length job
    start_job(0, 5);
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_m_valid", m_valid, 0);
    @(negedge clk);
    chk("t4_done_off", done, 0);
    chk("t4_busy_off", busy, 0);
    @(posedge clk); #1;

    // Test 5: reset mid-job, then a fresh job
    start_job(4, 0);
    send(mk(500, 0, 0, 0));
    send(mk(1, 2, 3, 4));
    @(negedge clk);
    chk("t5_sat_before_rst", sat_flag, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    s_valid = 1'b0;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("t5_after_rst");
    @(posedge clk); #1;
    start_job(1, 3);
    send(mk(-20, 12, 0, 0));
    s_valid = 1'b0;
    wait_done("t5_done");
    chk("t5_l0", lane(last_out, 0), -2);
    chk("t5_l1", lane(last_out, 1), 2);

    // Test 6: cfg_start during RUN is ignored
    start_job(2, 0);
    send(mk(50, 0, 0, 0));
    s_valid = 1'b0;
    cfg_start = 1'b1;
    cfg_len   = CW'(5);
    cfg_shift = SW'(4);
    tick(1);
    cfg_start = 1'b0;
    send(mk(100, 0, 0, 77));
    s_valid = 1'b0;
    wait_done("t6_done");
    chk("t6_l0", lane(last_out, 0), 100);
    chk("t6_l3", lane(last_out, 3), 77);
    tick(3);
    @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_valid", m_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
